// File: rtl/step_motor_pkg.sv
// step_motor_pkg: shared phase table, FSM state type and step-mode encoding for the stepper driver
package step_motor_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic FULL = 1'b1;
  localparam logic HALF = 1'b0;
  localparam logic [7:0][3:0] PHASE = {4'b1001, 4'b0001, 4'b0011, 4'b0010,
                                       4'b0110, 4'b0100, 4'b1100, 4'b1000};
endpackage

// File: rtl/step_motor_phase_driver_if.sv
// step_motor_phase_driver_if: run/step/dir control in, coil pattern and status out
// master: press/step control side; slave: the phase driver
interface step_motor_phase_driver_if #(parameter int POS_W = 16);
  logic run_in;
  logic step;
  logic dir;
  logic [3:0] coils;
  logic busy;
  logic step_done;
  logic [POS_W-1:0] position;
  modport master (output run_in, step, dir, input coils, busy, step_done, position);
  modport slave (input run_in, step, dir, output coils, busy, step_done, position);
endinterface

// File: rtl/step_tick_gen.sv
// step_tick_gen: STEP_DIV cycle divider producing a one-cycle tick while enabled
// ports: new_clk, rst (async active-low), enable (count), clear (return to 0), tick
module step_tick_gen #(parameter int STEP_DIV = 10) (
  input  logic new_clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic tick
);
  localparam int W = $clog2(STEP_DIV);
  logic [W-1:0] cnt;
  assign tick = enable && cnt == W'(STEP_DIV - 1);
  always_ff @(posedge new_clk or negedge rst)
    if (!rst) cnt <= '0;
    else cnt <= (clear || tick) ? '0 : enable ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/step_motor_phase_driver.sv
// step_motor_phase_driver: turns a run-enable level into timed full/half-step coil phases with a position count
// ports: new_clk, rst (async active-low), bus (slave: run_in/step/dir in; coils/busy/step_done/position out)
// COIL_RELEASE_EN: de-energize coils after RELEASE_CYCLES idle cycles
module step_motor_phase_driver
  import step_motor_pkg::*;
#(
  parameter int STEP_DIV = 10,
  parameter int POS_W = 16,
  parameter int RELEASE_CYCLES = 200
) (
  input logic new_clk,
  input logic rst,
  step_motor_phase_driver_if.slave bus
);
  state_t state, state_nxt;
  logic energize, en_nxt, tick, run_go, release_now;
  logic [2:0] idx, idx_nxt, mag, d;
  logic [POS_W-1:0] pos_nxt;
  assign run_go = state == RUN && bus.run_in;
  assign bus.busy = state == RUN;
  // counter held cleared whenever a step period cannot continue, so partial periods are dropped
  step_tick_gen #(.STEP_DIV(STEP_DIV)) u_tick (
    .new_clk(new_clk),
    .rst(rst),
    .enable(run_go),
    .clear(!run_go),
    .tick(tick)
  );
`ifdef COIL_RELEASE_EN
  localparam int RW = $clog2(RELEASE_CYCLES + 1);
  logic [RW-1:0] rel_cnt;
  logic idle;
  assign idle = state == IDLE && !bus.run_in && energize;
  assign release_now = idle && rel_cnt == RW'(RELEASE_CYCLES - 1);
  always_ff @(posedge new_clk or negedge rst)
    if (!rst) rel_cnt <= '0;
    else rel_cnt <= (idle && !release_now) ? rel_cnt + 1'b1 : '0;
`else
  localparam int unused_release = RELEASE_CYCLES;
  assign release_now = 1'b0;
`endif
  // full-step from an even (single-coil) index moves one half-step to reach a two-coil phase
  always_comb begin
    state_nxt = bus.run_in ? RUN : IDLE;
    mag = (bus.step == FULL && idx[0]) ? 3'd2 : 3'd1;
    d = bus.dir ? mag : 3'd0 - mag;
    idx_nxt = tick ? idx + d : idx;
    pos_nxt = tick ? bus.position + {{(POS_W - 3){d[2]}}, d} : bus.position;
    en_nxt = (state == IDLE && bus.run_in) || (energize && !release_now);
  end
  always_ff @(posedge new_clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      energize <= 1'b0;
      idx <= '0;
      bus.position <= '0;
      bus.coils <= '0;
      bus.step_done <= 1'b0;
    end else begin
      state <= state_nxt;
      energize <= en_nxt;
      idx <= idx_nxt;
      bus.position <= pos_nxt;
      bus.coils <= en_nxt ? PHASE[idx_nxt] : 4'b0000;
      bus.step_done <= tick;
    end
endmodule

// File: tb/tb_step_motor_phase_driver.sv
// tb_step_motor_phase_driver: directed and randomized checks of the stepper phase driver against a step-count model
module tb_step_motor_phase_driver;
  localparam int SD = 10;
  logic new_clk = 1'b0;
  logic rst = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  int pulses = 0;
  int midx = 0;
  logic [15:0] mpos = '0;
  logic [3:0] tbl [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011, 4'b0001, 4'b1001};
  step_motor_phase_driver_if #(.POS_W(16)) bus ();
  step_motor_phase_driver_if #(.POS_W(16)) bus2 ();
  step_motor_phase_driver #(.STEP_DIV(SD), .POS_W(16), .RELEASE_CYCLES(200)) dut (
    .new_clk(new_clk), .rst(rst), .bus(bus));
  step_motor_phase_driver #(.STEP_DIV(2), .POS_W(16), .RELEASE_CYCLES(200)) dut2 (
    .new_clk(new_clk), .rst(rst), .bus(bus2));
  always #5 new_clk = ~new_clk;
  always @(negedge new_clk) if (bus.step_done === 1'b1) pulses++;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model_step(input logic st, input logic dr);
    int d;
    d = (st && midx % 2 == 1) ? 2 : 1;
    if (!dr) d = -d;
    midx = (midx + d + 8) % 8;
    mpos = mpos + 16'(d);
  endtask
  // run_in sampled high at the entry edge and n further edges, then low; called just after a negedge
  task automatic run_for(input int n, input bit rnd, input logic st, input logic dr);
    bit ev;
    for (int i = 0; i <= n; i++) begin
      bus.run_in = 1'b1;
      bus.step = rnd ? 1'($urandom) : st;
      bus.dir = rnd ? 1'($urandom) : dr;
      @(posedge new_clk);
      ev = i > 0 && i % SD == 0;
      if (ev) model_step(bus.step, bus.dir);
      @(negedge new_clk);
      check("busy_run", {31'b0, bus.busy}, 32'd1);
      check("step_done", {31'b0, bus.step_done}, {31'b0, ev});
      check("coils_run", {28'b0, bus.coils}, {28'b0, tbl[midx]});
      check("pos_run", {16'b0, bus.position}, {16'b0, mpos});
    end
    bus.run_in = 1'b0;
    @(negedge new_clk);
    check("busy_drop", {31'b0, bus.busy}, 32'd0);
    check("done_drop", {31'b0, bus.step_done}, 32'd0);
    check("coils_hold", {28'b0, bus.coils}, {28'b0, tbl[midx]});
    check("pos_hold", {16'b0, bus.position}, {16'b0, mpos});
  endtask
  initial begin
    int p0;
    int n;
    bus.run_in = 1'b0; bus.step = 1'b0; bus.dir = 1'b0;
    bus2.run_in = 1'b0; bus2.step = 1'b0; bus2.dir = 1'b0;
    repeat (2) @(negedge new_clk);
    check("rst_coils", {28'b0, bus.coils}, 32'd0);
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_done", {31'b0, bus.step_done}, 32'd0);
    check("rst_pos", {16'b0, bus.position}, 32'd0);
    rst = 1'b1;
    @(negedge new_clk);
    #1 p0 = pulses;
    run_for(50, 0, 1'b1, 1'b1);
    #1 check("full50_pulses", pulses - p0, 32'd5);
    check("full50_coils", {28'b0, bus.coils}, 32'b1100);
    check("full50_pos", {16'b0, bus.position}, 32'd9);
    p0 = pulses;
    @(negedge new_clk);
    run_for(100, 0, 1'b0, 1'b0);
    #1 check("half100_pulses", pulses - p0, 32'd10);
    check("half100_coils", {28'b0, bus.coils}, 32'b1001);
    check("half100_pos", {16'b0, bus.position}, 32'hffff);
    repeat (2) begin
      p0 = pulses;
      @(negedge new_clk);
      run_for(19, 0, 1'b1, 1'b0);
      #1 check("run19_pulses", pulses - p0, 32'd1);
    end
    repeat (6) begin
      n = $urandom_range(45, 1);
      @(negedge new_clk);
      run_for(n, 1, 1'b0, 1'b0);
      repeat ($urandom_range(4, 0)) begin
        @(negedge new_clk);
        check("idle_coils", {28'b0, bus.coils}, {28'b0, tbl[midx]});
        check("idle_busy", {31'b0, bus.busy}, 32'd0);
      end
    end
    repeat (190) @(negedge new_clk);
    check("release_early", {28'b0, bus.coils}, {28'b0, tbl[midx]});
    repeat (70) @(negedge new_clk);
`ifdef COIL_RELEASE_EN
    check("release_late", {28'b0, bus.coils}, 32'd0);
`else
    check("hold_late", {28'b0, bus.coils}, {28'b0, tbl[midx]});
`endif
    check("release_pos", {16'b0, bus.position}, {16'b0, mpos});
    run_for(5, 0, 1'b1, 1'b1);
    bus.run_in = 1'b1;
    repeat (25) @(posedge new_clk);
    #2 rst = 1'b0;
    #1 check("arst_coils", {28'b0, bus.coils}, 32'd0);
    check("arst_pos", {16'b0, bus.position}, 32'd0);
    check("arst_busy", {31'b0, bus.busy}, 32'd0);
    midx = 0;
    mpos = '0;
    p0 = pulses;
    repeat (20) @(negedge new_clk);
    #1 check("arst_nopulse", pulses - p0, 32'd0);
    bus.run_in = 1'b0;
    rst = 1'b1;
    repeat (5) @(negedge new_clk);
    #1 check("arst_after", pulses - p0, 32'd0);
    check("arst_coils_idle", {28'b0, bus.coils}, 32'd0);
    @(negedge new_clk);
    bus2.run_in = 1'b1; bus2.step = 1'b1; bus2.dir = 1'b1;
    repeat (32769) @(posedge new_clk);
    @(negedge new_clk);
    check("wrap_max", {16'b0, bus2.position}, 32'h7fff);
    check("wrap_max_coils", {28'b0, bus2.coils}, 32'b1001);
    bus2.step = 1'b0;
    repeat (2) @(posedge new_clk);
    @(negedge new_clk);
    check("wrap_min", {16'b0, bus2.position}, 32'h8000);
    check("wrap_coils", {28'b0, bus2.coils}, 32'b1000);
    check("wrap_done", {31'b0, bus2.step_done}, 32'd1);
    bus2.run_in = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
